// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM encodings and
// the hard-wired zero register number.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MD_BUSY  = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller. The controller is the
// slave; the surrounding pipeline (or a bench) is the master.
interface hazard_ctrl_if;

  logic [4:0]  IFID_RegRs;
  logic [4:0]  IFID_RegRt;
  logic        IDEX_MemRead;
  logic [4:0]  IDEX_RegRt;
  logic        IDEX_MD_Start;
  logic        EX_BranchTaken;
  logic        EXMEM_MemReq;
  logic        DMem_Ack;

  logic        PC_Write;
  logic        IFID_Write;
  logic        IFID_Flush;
  logic        IDEX_Write;
  logic        IDEX_Flush;
  logic        EXMEM_Write;
  logic        EXMEM_Flush;
  logic        MEMWB_Flush;
  logic        MD_Busy;
  logic        MD_Done;
  logic [31:0] Stall_Cycles;
  logic [1:0]  State;

  modport master (
    output IFID_RegRs, IFID_RegRt, IDEX_MemRead, IDEX_RegRt, IDEX_MD_Start,
           EX_BranchTaken, EXMEM_MemReq, DMem_Ack,
    input  PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, EXMEM_Flush, MEMWB_Flush, MD_Busy, MD_Done,
           Stall_Cycles, State
  );

  modport slave (
    input  IFID_RegRs, IFID_RegRt, IDEX_MemRead, IDEX_RegRt, IDEX_MD_Start,
           EX_BranchTaken, EXMEM_MemReq, DMem_Ack,
    output PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush,
           EXMEM_Write, EXMEM_Flush, MEMWB_Flush, MD_Busy, MD_Done,
           Stall_Cycles, State
  );

endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Mult/div occupancy timer: a start loads MD_LATENCY-1, the count then falls
// once per cycle and done marks the final busy cycle.
module md_timer #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic busy,
  output logic done
);

  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_LATENCY - 1);

  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;

  // Counting continues through memory stalls so the unit's latency is fixed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      cnt_q  <= LOAD_VAL;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) begin
        busy_q <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign busy = busy_q;
  assign done = busy_q & (cnt_q == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, mult/div
// occupancy and data-memory wait states, plus a saturating stall counter.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hif
);

  hz_state_t   state_q, state_nxt;
  logic        mem_stall, load_use;
  logic        md_busy, md_done, md_go;
  logic        pc_w, ifid_w, ifid_f, idex_w, idex_f, exmem_w, exmem_f, memwb_f;
  logic [31:0] stall_q;

  md_timer #(
    .MD_LATENCY (MD_LATENCY),
    .CNT_W      (CNT_W)
  ) u_md_timer (
    .clk   (clk),
    .rst   (rst),
    .start (md_go),
    .busy  (md_busy),
    .done  (md_done)
  );

  // In MEM_WAIT the underlying state is implied by the timer, so the ack cycle
  // falls through to either the mult/div rule or the RUN rules below.
  always_comb begin
    mem_stall = hif.EXMEM_MemReq & ~hif.DMem_Ack;
    load_use  = hif.IDEX_MemRead & (hif.IDEX_RegRt != REG_ZERO) &
                ((hif.IDEX_RegRt == hif.IFID_RegRs) |
                 (hif.IDEX_RegRt == hif.IFID_RegRt));

    pc_w    = 1'b1;
    ifid_w  = 1'b1;
    ifid_f  = 1'b0;
    idex_w  = 1'b1;
    idex_f  = 1'b0;
    exmem_w = 1'b1;
    exmem_f = 1'b0;
    memwb_f = 1'b0;
    md_go   = 1'b0;

    if (mem_stall) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_w = 1'b0;
      memwb_f = 1'b1;
    end else if (md_busy) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_w  = 1'b0;
      exmem_f = 1'b1;
    end else if (hif.EX_BranchTaken) begin
      ifid_f  = 1'b1;
      idex_f  = 1'b1;
    end else if (hif.IDEX_MD_Start) begin
      md_go   = 1'b1;
    end else if (load_use) begin
      pc_w    = 1'b0;
      ifid_w  = 1'b0;
      idex_f  = 1'b1;
    end

    state_nxt = ST_RUN;
    if (mem_stall) begin
      state_nxt = ST_MEM_WAIT;
    end else if (md_go || (md_busy && !md_done)) begin
      state_nxt = ST_MD_BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (!pc_w && !(&stall_q)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  // Reset forces every enable and flush low, not just the registers.
  assign hif.PC_Write     = rst & pc_w;
  assign hif.IFID_Write   = rst & ifid_w;
  assign hif.IFID_Flush   = rst & ifid_f;
  assign hif.IDEX_Write   = rst & idex_w;
  assign hif.IDEX_Flush   = rst & idex_f;
  assign hif.EXMEM_Write  = rst & exmem_w;
  assign hif.EXMEM_Flush  = rst & exmem_f;
  assign hif.MEMWB_Flush  = rst & memwb_f;
  assign hif.MD_Busy      = md_busy;
  assign hif.MD_Done      = md_done;
  assign hif.Stall_Cycles = stall_q;
  assign hif.State        = state_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MD_LATENCY=4: stimulus pushes
// hand-computed expectations, a monitor pops and compares them.
module tb_hazard_ctrl;

  logic clk;
  logic rst;

  hazard_ctrl_if hif();

  hazard_ctrl #(
    .MD_LATENCY (4),
    .CNT_W      (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .hif (hif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector bit order:
  // {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Flush, EXMEM_Write, EXMEM_Flush, MEMWB_Flush}
  localparam logic [7:0] C_RST = 8'h00;
  localparam logic [7:0] C_DEF = 8'hD4;
  localparam logic [7:0] C_LU  = 8'h1C;
  localparam logic [7:0] C_BR  = 8'hFC;
  localparam logic [7:0] C_MD  = 8'h06;
  localparam logic [7:0] C_MW  = 8'h01;

  typedef struct {
    string       name;
    logic [7:0]  ctl;
    logic        busy;
    logic        done;
    logic [1:0]  st;
    logic [31:0] stall;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  event async_chk;

  task automatic push(input string nm, input logic [7:0] c, input logic b,
                      input logic d, input logic [1:0] s, input logic [31:0] sc);
    exp_t e;
    e.name = nm; e.ctl = c; e.busy = b; e.done = d; e.st = s; e.stall = sc;
    q.push_back(e);
  endtask

  task automatic cyc(input string nm, input logic [7:0] c, input logic b,
                     input logic d, input logic [1:0] s, input logic [31:0] sc);
    push(nm, c, b, d, s, sc);
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic [4:0] irt, input logic [4:0] rs,
                       input logic [4:0] rt, input logic mds, input logic br,
                       input logic mq, input logic ack);
    hif.IDEX_MemRead   = mr;
    hif.IDEX_RegRt     = irt;
    hif.IFID_RegRs     = rs;
    hif.IFID_RegRt     = rt;
    hif.IDEX_MD_Start  = mds;
    hif.EX_BranchTaken = br;
    hif.EXMEM_MemReq   = mq;
    hif.DMem_Ack       = ack;
  endtask

  // Monitor: compares every pending expectation on the falling edge, or at
  // once when the stimulus asks for an off-edge check.
  initial begin
    exp_t e;
    logic [7:0] act;
    forever begin
      @(negedge clk or async_chk);
      while (q.size() > 0) begin
        e   = q.pop_front();
        act = {hif.PC_Write, hif.IFID_Write, hif.IFID_Flush, hif.IDEX_Write,
               hif.IDEX_Flush, hif.EXMEM_Write, hif.EXMEM_Flush, hif.MEMWB_Flush};
        checks++;
        if ({act, hif.MD_Busy, hif.MD_Done, hif.State} !== {e.ctl, e.busy, e.done, e.st}) begin
          failures++;
          $display("FAIL %s ctl/busy/done/state got=%b/%b/%b/%0d want=%b/%b/%b/%0d",
                   e.name, act, hif.MD_Busy, hif.MD_Done, hif.State,
                   e.ctl, e.busy, e.done, e.st);
        end
        checks++;
        if (hif.Stall_Cycles !== e.stall) begin
          failures++;
          $display("FAIL %s_stall Stall_Cycles got=%0d want=%0d", e.name, hif.Stall_Cycles, e.stall);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    cyc("reset", C_RST, 0, 0, 0, 0);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) cyc("idle", C_DEF, 0, 0, 0, 0);

    // Load-use on rs, then zero-register and rt variants.
    drive(1, 8, 8, 0, 0, 0, 0, 0);  cyc("load_use_rs", C_LU, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("lu_after", C_DEF, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);  cyc("lu_reg_zero", C_DEF, 0, 0, 0, 1);
    drive(1, 9, 3, 9, 0, 0, 0, 0);  cyc("load_use_rt", C_LU, 0, 0, 0, 1);
    drive(1, 9, 3, 4, 0, 0, 0, 0);  cyc("lu_no_match", C_DEF, 0, 0, 0, 2);

    // Branch beats load-use.
    drive(1, 8, 8, 0, 0, 1, 0, 0);  cyc("branch_lu", C_BR, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("br_after", C_DEF, 0, 0, 0, 2);

    // Mult/div: 4 busy cycles, done on the last.
    drive(0, 0, 0, 0, 1, 0, 0, 0);  cyc("md_start", C_DEF, 0, 0, 0, 2);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("md_b1", C_MD, 1, 0, 1, 2);
    cyc("md_b2", C_MD, 1, 0, 1, 3);
    cyc("md_b3", C_MD, 1, 0, 1, 4);
    cyc("md_b4", C_MD, 1, 1, 1, 5);
    cyc("md_after", C_DEF, 0, 0, 0, 6);

    // Branch together with MD start: no MD entry.
    drive(0, 0, 0, 0, 1, 1, 0, 0);  cyc("br_md", C_BR, 0, 0, 0, 6);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("br_md_after", C_DEF, 0, 0, 0, 6);

    // Data-memory wait of three cycles, then ack.
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    cyc("mw_1", C_MW, 0, 0, 0, 6);
    cyc("mw_2", C_MW, 0, 0, 2, 7);
    cyc("mw_3", C_MW, 0, 0, 2, 8);
    drive(0, 0, 0, 0, 0, 0, 1, 1);  cyc("mw_ack", C_DEF, 0, 0, 2, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mw_after", C_DEF, 0, 0, 0, 9);

    // Memory wait in the middle of a mult/div: counting continues.
    drive(0, 0, 0, 0, 1, 0, 0, 0);  cyc("mdm_start", C_DEF, 0, 0, 0, 9);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mdm_b1", C_MD, 1, 0, 1, 9);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  cyc("mdm_b2", C_MW, 1, 0, 1, 10);
    cyc("mdm_b3", C_MW, 1, 0, 2, 11);
    drive(0, 0, 0, 0, 0, 0, 1, 1);  cyc("mdm_b4_ack", C_MD, 1, 1, 2, 12);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mdm_after", C_DEF, 0, 0, 0, 13);

    // Mult/div finishing while memory stalls: done pulses, then MEM_WAIT.
    drive(0, 0, 0, 0, 1, 0, 0, 0);  cyc("mdd_start", C_DEF, 0, 0, 0, 13);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    cyc("mdd_b1", C_MD, 1, 0, 1, 13);
    cyc("mdd_b2", C_MD, 1, 0, 1, 14);
    cyc("mdd_b3", C_MD, 1, 0, 1, 15);
    drive(0, 0, 0, 0, 0, 0, 1, 0);  cyc("mdd_b4_stall", C_MW, 1, 1, 1, 16);
    drive(0, 0, 0, 0, 0, 0, 1, 1);  cyc("mdd_ack", C_DEF, 0, 0, 2, 17);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mdd_after", C_DEF, 0, 0, 0, 17);

    // Asynchronous reset in MD busy cycle 2.
    drive(0, 0, 0, 0, 1, 0, 0, 0);  cyc("mdr_start", C_DEF, 0, 0, 0, 17);
    drive(0, 0, 0, 0, 0, 0, 0, 0);  cyc("mdr_b1", C_MD, 1, 0, 1, 17);
    push("mdr_b2", C_MD, 1, 0, 1, 18);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    push("async_rst", C_RST, 0, 0, 0, 0);
    -> async_chk;
    @(posedge clk);
    #1;
    cyc("rst_hold", C_RST, 0, 0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) cyc("post_rst", C_DEF, 0, 0, 0, 0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding logic.
- Resolves the hazards that forwarding cannot cover:
  - load-use stalls
  - taken-branch flushes
  - multi-cycle mult/div occupancy
  - data-memory wait states
- Drives per-stage write-enable and flush controls. Keeps a saturating stall-cycle counter.

Parameters:
MD_LATENCY, 32, cycles a mult/div occupies EX, counted from the cycle after IDEX_MD_Start; legal range 2..63
CNT_W, 6, width of the mult/div down-counter; must satisfy 2^CNT_W > MD_LATENCY

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
IFID_RegRs  in  5  rs field of instruction in ID
IFID_RegRt  in  5  rt field of instruction in ID
IDEX_MemRead  in  1  instruction in EX is a load
IDEX_RegRt  in  5  destination rt of instruction in EX
IDEX_MD_Start  in  1  instruction in EX is mult/div, first EX cycle
EX_BranchTaken  in  1  branch/jump resolved taken in EX
EXMEM_MemReq  in  1  instruction in MEM accesses data memory
DMem_Ack  in  1  data memory completes access this cycle
PC_Write  out  1  PC update enable
IFID_Write  out  1  IF/ID register enable
IFID_Flush  out  1  IF/ID loads bubble
IDEX_Write  out  1  ID/EX register enable
IDEX_Flush  out  1  ID/EX loads bubble
EXMEM_Write  out  1  EX/MEM register enable
EXMEM_Flush  out  1  EX/MEM loads bubble
MEMWB_Flush  out  1  MEM/WB loads bubble
MD_Busy  out  1  mult/div occupying EX
MD_Done  out  1  one-cycle pulse, mult/div result valid
Stall_Cycles  out  32  saturating count of cycles with PC_Write=0
State  out  2  current state: 0 RUN, 1 MD_BUSY, 2 MEM_WAIT

Behaviour:
- State register, md counter and Stall_Cycles are registered. Control outputs are combinational from state and inputs.
- While rst=0: State=RUN, counter=0, Stall_Cycles=0, MD_Busy=0, MD_Done=0. All Write outputs are 0 and all Flush outputs are 0.
- Internal terms:
  - mem_stall = EXMEM_MemReq & ~DMem_Ack
  - load_use = IDEX_MemRead & IDEX_RegRt!=0 & (IDEX_RegRt==IFID_RegRs | IDEX_RegRt==IFID_RegRt)
- Default (no condition active): all Write=1, all Flush=0.
- Conditions in priority order, highest first:
  1. mem_stall, any state: all Write=0, MEMWB_Flush=1, other Flush=0. State becomes MEM_WAIT at the next edge; it returns to the underlying state on the edge after the DMem_Ack=1 cycle. The ack cycle itself uses the lower-priority rules.
  2. State MD_BUSY: PC_Write=IFID_Write=IDEX_Write=0, EXMEM_Flush=1, MD_Busy=1.
  3. EX_BranchTaken (RUN only): IFID_Flush=1, IDEX_Flush=1, PC_Write=1 (target load). load_use is ignored.
  4. IDEX_MD_Start (RUN only): counter loads MD_LATENCY-1 and State becomes MD_BUSY at the next edge. The current cycle uses default outputs.
  5. load_use (RUN only): PC_Write=0, IFID_Write=0, IDEX_Flush=1, for exactly one cycle per occurrence.
- Mult/div timing:
  - In MD_BUSY the counter decrements every cycle, including during mem_stall.
  - At counter==0, MD_Done=1 for that cycle and the state returns to RUN. If mem_stall is active, it goes to MEM_WAIT instead, with MD_Done still pulsing.
  - Total MD_Busy duration is MD_LATENCY cycles.
- EX_BranchTaken together with IDEX_MD_Start is illegal. The branch wins and no MD_BUSY entry occurs.
- Branch or MD start arriving during mem_stall is held by the frozen ID/EX and acted on in the ack cycle.
- Stall_Cycles increments on every edge where PC_Write=0, and saturates at 0xFFFFFFFF.
- Reset asserted mid-MD or mid-wait aborts immediately to reset values. MD_Done does not fire.

Decomposition:
- Shared package: state encodings RUN/MD_BUSY/MEM_WAIT and the REG_ZERO=5'd0 constant.
- One natural sub-module: md_timer (load/decrement/done counter, parameterised by MD_LATENCY and CNT_W).

Test Plan:
- Reset release, no requests: all Write=1, Flush=0, State=0, Stall_Cycles=0 after 10 cycles.
- IDEX_MemRead=1, IDEX_RegRt=8, IFID_RegRs=8 for one cycle:
  - PC_Write=0, IFID_Write=0, IDEX_Flush=1 that cycle.
  - Stall_Cycles=1 afterwards.
  - With IDEX_RegRt=0: no stall.
- EX_BranchTaken=1 with load_use also true: IFID_Flush=IDEX_Flush=1, PC_Write=1, Stall_Cycles unchanged.
- MD_LATENCY=4, IDEX_MD_Start pulse: MD_Busy=1 for 4 cycles, MD_Done on the 4th, EXMEM_Flush=1 throughout, State returns to 0, Stall_Cycles=4.
- EXMEM_MemReq=1 with DMem_Ack low for 3 cycles then high:
  - All Write=0 and MEMWB_Flush=1 for 3 cycles; State=2 during the wait.
  - Ack cycle uses normal outputs; Stall_Cycles=3.
- rst driven low in MD_BUSY cycle 2: outputs go to reset values asynchronously; after release State=0 and MD_Done never pulsed.
